uart_tx: RTL and testbench
==========================

# uart_tx

UART transmitter for the board-level design: accepts bytes over a valid/ready handshake, buffers them in a small FIFO, and serialises them onto the UTXD pin as 8-bit, LSB-first frames with optional parity and 1 or 2 stop bits. It is the transmit counterpart of the design's URXD receive path and shares its bit timing: 26 µs bits, 1300 cycles of the 50 MHz clock. Frames are sent back-to-back with no idle gap while data is queued.

## Interface
- BIT_CYCLES, 1300: clock cycles per bit (26 µs at 50 MHz); must be ≥ 2.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: byte FIFO depth; power of two, ≥ 2.
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- tx_data  input  8  byte to send; sampled on an accepting edge.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  FIFO not full; high means a byte can be accepted.
- txd  output  1  serial line; idle high; drives UTXD.
- busy  output  1  high while a frame is on the line (START through the last STOP).
- fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes waiting in the FIFO; excludes the byte being shifted.

## Operation
- Accept: a byte is written at a rising edge where tx_valid && tx_ready. With tx_ready low, tx_valid is ignored and tx_data is not sampled.
- tx_ready = (fifo_count != FIFO_DEPTH), computed combinationally from registered state. A pop in the same cycle does not re-open a full FIFO.
- FSM states and transitions:
  - IDLE -> START when the FIFO is non-empty. On that edge the FSM pops the head into the shift register and drives txd low.
  - START -> DATA.
  - DATA covers 8 bits, shifted out LSB first.
  - DATA -> PARITY if PARITY != 0; otherwise DATA -> STOP.
  - STOP lasts STOP_BITS bits, with txd high.
  - After the last stop bit: if the FIFO is non-empty, pop and go straight to START on the same edge. Otherwise go to IDLE.
- Every state holds for exactly BIT_CYCLES cycles. A bit counter counts 0..BIT_CYCLES-1 and a bit index counts 0..7.
- Parity bit:
  - Even: XOR of the 8 data bits.
  - Odd: the inverse of that XOR.
- txd is driven from a flip-flop and never from combinational logic, so it is glitch-free.
- busy is registered and is high in every state except IDLE.
- Simultaneous push and pop in one cycle leave fifo_count unchanged. The pushed byte is queued behind the remaining bytes.
- FIFO pointers wrap modulo FIFO_DEPTH. A full/empty flag is needed beyond the pointers.
- Reset (asynchronous, any time, including mid-frame):
  - The in-progress frame is abandoned and the FIFO is flushed.
  - Outputs immediately become txd=1, busy=0, tx_ready=1, fifo_count=0.
  - All counters clear.
  - After rst_n deasserts, nothing is transmitted until a new byte is accepted.

## Timing
- Latency: if the FSM is IDLE and the FIFO is empty, a byte accepted at edge N causes txd to fall at edge N+1. busy rises and fifo_count returns to 0 at the same edge.
- Frame length in cycles is BIT_CYCLES × (10 + (PARITY!=0) + (STOP_BITS-1)). The default is 13000 cycles (260 µs).
- Data bit k occupies txd from BIT_CYCLES×(1+k) to BIT_CYCLES×(2+k)-1 cycles after the falling edge of the start bit.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle, with zero idle cycles and no busy drop.
- Capacity: the first byte moves to the shifter one cycle after acceptance, so a burst from idle accepts FIFO_DEPTH+1 bytes before tx_ready falls.
- After the final frame: busy falls, and txd stays high, on the edge that ends the last stop bit.

## Test plan
- Single byte, defaults: 0xA5 accepted at edge N.
  - Required: txd=0 for cycles N+1..N+1300.
  - Then bits 1,0,1,0,0,1,0,1 at 1300 cycles each.
  - Then stop high for 1300 cycles, and busy low exactly 13000 cycles after txd falls.
- Parity:
  - PARITY=1, byte 0x07: parity bit 1.
  - PARITY=2, byte 0x07: parity bit 0.
  - PARITY=1, byte 0x00: parity bit 0.
  - Frame length is 11×BIT_CYCLES in each case.
- Burst/full: hold tx_valid with 0x10..0x16 from idle, using BIT_CYCLES=4.
  - Required: exactly 5 accepted before tx_ready falls.
  - fifo_count peaks at 4.
  - 5 contiguous frames with no idle cycle, in order 0x10..0x14.
  - tx_ready re-rises one cycle after each pop.
- Two stop bits: STOP_BITS=2, bytes 0x55 then 0xAA.
  - Required: txd high for exactly 2×BIT_CYCLES between the last data bit of 0x55 and the start bit of 0xAA.
- Reset mid-frame: assert rst_n=0 during data bit 3 with 2 bytes queued.
  - Required: txd=1, busy=0, fifo_count=0 and tx_ready=1 immediately, without waiting for a clock.
  - No further frame after release until a new write.
- Loopback: connect txd to the design's UART receiver at 1300 cycles/bit and send 0x00, 0xFF, 0x55.
  - Required: the receiver reports all three bytes with no framing error.

Source files
------------

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - FIFO-buffered UART transmitter, 8 data bits LSB first, optional parity, 1 or 2 stop bits
module uart_tx #(
  parameter int BIT_CYCLES = 1300,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t        state_q;
  logic [CW-1:0] bit_cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic          txd_q;
  logic          busy_q;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;

  logic          push;
  logic          pop;
  logic          bit_end;
  logic [7:0]    head;

  // The occupancy counter doubles as the full/empty flag the wrapping pointers cannot provide.
  assign tx_ready   = (count_q != FULL_CNT);
  assign push       = tx_valid && tx_ready;
  assign head       = mem_q[rd_ptr_q];
  assign bit_end    = (bit_cnt_q == BIT_LAST);
  assign pop        = (count_q != '0) &&
                      ((state_q == S_IDLE) ||
                       (state_q == S_STOP && bit_end && bit_idx_q == STOP_LAST));
  assign txd        = txd_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          bit_cnt_q <= '0;
          if (pop) begin
            shift_q <= head;
            par_q   <= (^head) ^ (PARITY == 2);
            txd_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START, S_DATA, S_PARITY, S_STOP: begin
          if (!bit_end) begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end else begin
            bit_cnt_q <= '0;
            case (state_q)
              S_START: begin
                txd_q     <= shift_q[0];
                bit_idx_q <= '0;
                state_q   <= S_DATA;
              end
              S_DATA: begin
                shift_q <= {1'b0, shift_q[7:1]};
                if (bit_idx_q == 3'd7) begin
                  bit_idx_q <= '0;
                  if (PARITY != 0) begin
                    txd_q   <= par_q;
                    state_q <= S_PARITY;
                  end else begin
                    txd_q   <= 1'b1;
                    state_q <= S_STOP;
                  end
                end else begin
                  bit_idx_q <= bit_idx_q + 1'b1;
                  txd_q     <= shift_q[1];
                end
              end
              S_PARITY: begin
                txd_q     <= 1'b1;
                bit_idx_q <= '0;
                state_q   <= S_STOP;
              end
              default: begin
                // Last stop bit: chain straight into the next frame when a byte is waiting.
                if (bit_idx_q == STOP_LAST) begin
                  bit_idx_q <= '0;
                  if (pop) begin
                    shift_q <= head;
                    par_q   <= (^head) ^ (PARITY == 2);
                    txd_q   <= 1'b0;
                    state_q <= S_START;
                  end else begin
                    txd_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                  end
                end else begin
                  bit_idx_q <= bit_idx_q + 1'b1;
                end
              end
            endcase
          end
        end
        default: begin
          state_q <= S_IDLE;
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx across default, parity, burst and two-stop configurations
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] vld = '0;
  logic [7:0] dat [4];
  logic [3:0] rdy_w, txd_w, busy_w;
  logic [2:0] fc_w [4];

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  // 0: defaults, 1: even parity fast, 2: odd parity fast, 3: two stop bits fast
  uart_tx #(.BIT_CYCLES(1300), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst_n(rst_n), .tx_data(dat[0]), .tx_valid(vld[0]), .tx_ready(rdy_w[0]),
    .txd(txd_w[0]), .busy(busy_w[0]), .fifo_count(fc_w[0]));
  uart_tx #(.BIT_CYCLES(4), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst_n(rst_n), .tx_data(dat[1]), .tx_valid(vld[1]), .tx_ready(rdy_w[1]),
    .txd(txd_w[1]), .busy(busy_w[1]), .fifo_count(fc_w[1]));
  uart_tx #(.BIT_CYCLES(4), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_c (
    .clk(clk), .rst_n(rst_n), .tx_data(dat[2]), .tx_valid(vld[2]), .tx_ready(rdy_w[2]),
    .txd(txd_w[2]), .busy(busy_w[2]), .fifo_count(fc_w[2]));
  uart_tx #(.BIT_CYCLES(4), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_d (
    .clk(clk), .rst_n(rst_n), .tx_data(dat[3]), .tx_valid(vld[3]), .tx_ready(rdy_w[3]),
    .txd(txd_w[3]), .busy(busy_w[3]), .fifo_count(fc_w[3]));

  function automatic logic [15:0] frame_bits(input logic [7:0] d, input int par, input int nslots);
    logic [15:0] b;
    b = '1;
    b[0] = 1'b0;
    b[8:1] = d;
    if (par != 0) b[9] = (par == 1) ? ^d : ~^d;
    return b & 16'((1 << nslots) - 1);
  endfunction

  task automatic push_byte(input int idx, input logic [7:0] d, output bit acc);
    @(negedge clk);
    dat[idx] = d;
    vld[idx] = 1'b1;
    acc = rdy_w[idx];
    @(posedge clk);
    #1 vld[idx] = 1'b0;
    if (acc) exp_q.push_back(d);
  endtask

  task automatic collect_frame(input int idx, input int bc, input int nslots,
                               output logic [15:0] bits, output int unstable, output int busy_drop,
                               output int gap, output logic [2:0] fc_start, output logic rdy_start,
                               output logic rdy_last, output bit timeout);
    logic v;
    bits = '0; unstable = 0; busy_drop = 0; gap = 0; timeout = 0;
    fc_start = '0; rdy_start = 1'b0; rdy_last = 1'b0;
    @(negedge clk);
    while (txd_w[idx] !== 1'b0 && gap < 20 * bc + 20) begin
      gap++;
      @(negedge clk);
    end
    if (txd_w[idx] !== 1'b0) begin
      timeout = 1;
      return;
    end
    fc_start  = fc_w[idx];
    rdy_start = rdy_w[idx];
    for (int s = 0; s < nslots; s++) begin
      for (int c = 0; c < bc; c++) begin
        if (s != 0 || c != 0) @(negedge clk);
        v = txd_w[idx];
        if (c == 0) bits[s] = v;
        else if (v !== bits[s]) unstable++;
        if (busy_w[idx] !== 1'b1) busy_drop++;
      end
    end
    rdy_last = rdy_w[idx];
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({txd_w[i], busy_w[i], rdy_w[i], fc_w[i]} !== {1'b1, 1'b0, 1'b1, 3'd0}) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: txd/busy/ready/count got %b/%b/%b/%0d want 1/0/1/0",
                 i, txd_w[i], busy_w[i], rdy_w[i], fc_w[i]);
      end
    end
  endtask

  task automatic test_single_byte();
    bit acc; logic [15:0] bits, e; int uns, bd, gap; logic [2:0] fc; logic rs, rl; bit to;
    logic [7:0] d;
    push_byte(0, 8'hA5, acc);
    collect_frame(0, 1300, 10, bits, uns, bd, gap, fc, rs, rl, to);
    d = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    e = frame_bits(d, 0, 10);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL single_timeout: no start bit seen"); end
    n_checks++;
    if (gap !== 1) begin n_fail++; $display("FAIL single_latency: got %0d cycles want 1", gap); end
    n_checks++;
    if (bits !== e) begin n_fail++; $display("FAIL single_bits: got %h want %h", bits, e); end
    n_checks++;
    if (uns !== 0 || bd !== 0) begin
      n_fail++; $display("FAIL single_stable: unstable %0d busy_drops %0d want 0/0", uns, bd);
    end
    n_checks++;
    if (fc !== 3'(exp_q.size())) begin
      n_fail++; $display("FAIL single_count: got %0d want %0d", fc, exp_q.size());
    end
    @(negedge clk);
    n_checks++;
    if (busy_w[0] !== 1'b0 || txd_w[0] !== 1'b1) begin
      n_fail++; $display("FAIL single_end: busy/txd got %b/%b want 0/1", busy_w[0], txd_w[0]);
    end
  endtask

  task automatic test_parity(input int idx, input int par, input logic [7:0] d_in, input logic pbit);
    bit acc; logic [15:0] bits, e; int uns, bd, gap; logic [2:0] fc; logic rs, rl; bit to;
    logic [7:0] d;
    push_byte(idx, d_in, acc);
    collect_frame(idx, 4, 11, bits, uns, bd, gap, fc, rs, rl, to);
    d = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    e = frame_bits(d, par, 11);
    n_checks++;
    if (bits !== e || to) begin
      n_fail++; $display("FAIL parity%0d_frame: got %h want %h (timeout %0d)", par, bits, e, to);
    end
    n_checks++;
    if (bits[9] !== pbit) begin
      n_fail++; $display("FAIL parity%0d_bit %h: got %b want %b", par, d_in, bits[9], pbit);
    end
    @(negedge clk);
    n_checks++;
    if (busy_w[idx] !== 1'b0 || uns !== 0 || bd !== 0) begin
      n_fail++; $display("FAIL parity%0d_len: busy %b unstable %0d drops %0d want 0/0/0",
                         par, busy_w[idx], uns, bd);
    end
  endtask

  task automatic test_burst();
    int acc_n, peak, low_at; logic r; logic prev_rl;
    acc_n = 0; peak = 0; low_at = -1; prev_rl = 1'b1;
    fork
      begin
        @(negedge clk);
        for (int cyc = 0; cyc < 20 && low_at < 0; cyc++) begin
          vld[1] = 1'b1;
          dat[1] = 8'(8'h10 + acc_n);
          r = rdy_w[1];
          @(posedge clk);
          if (r) begin exp_q.push_back(dat[1]); acc_n++; end
          @(negedge clk);
          if (int'(fc_w[1]) > peak) peak = int'(fc_w[1]);
          if (rdy_w[1] !== 1'b1) low_at = acc_n;
        end
        vld[1] = 1'b0;
      end
      begin
        logic [15:0] bits, e; int uns, bd, gap; logic [2:0] fc; logic rs, rl; bit to;
        logic [7:0] d;
        for (int f = 0; f < 5; f++) begin
          collect_frame(1, 4, 11, bits, uns, bd, gap, fc, rs, rl, to);
          d = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
          e = frame_bits(8'(8'h10 + f), 1, 11);
          n_checks++;
          if (bits !== e || d !== 8'(8'h10 + f) || to) begin
            n_fail++; $display("FAIL burst_frame%0d: got %h (sb %h) want %h", f, bits, d, e);
          end
          if (f > 0) begin
            n_checks++;
            if (gap !== 0 || uns !== 0 || bd !== 0 || fc !== 3'(exp_q.size())) begin
              n_fail++; $display("FAIL burst_contig%0d: gap %0d unstable %0d drops %0d count %0d want 0/0/0/%0d",
                                 f, gap, uns, bd, fc, exp_q.size());
            end
          end
          if (f == 1) begin
            n_checks++;
            if (prev_rl !== 1'b0 || rs !== 1'b1) begin
              n_fail++; $display("FAIL burst_ready_reopen: before pop %b after pop %b want 0/1", prev_rl, rs);
            end
          end
          prev_rl = rl;
        end
      end
    join
    n_checks++;
    if (low_at !== 5) begin n_fail++; $display("FAIL burst_accepted: got %0d want 5", low_at); end
    n_checks++;
    if (peak !== 4) begin n_fail++; $display("FAIL burst_peak_count: got %0d want 4", peak); end
    @(negedge clk);
    n_checks++;
    if (busy_w[1] !== 1'b0) begin n_fail++; $display("FAIL burst_end_busy: got %b want 0", busy_w[1]); end
  endtask

  task automatic test_two_stop();
    bit acc; logic [15:0] bits, e; int uns, bd, gap; logic [2:0] fc; logic rs, rl; bit to;
    logic [7:0] d;
    push_byte(3, 8'h55, acc);
    push_byte(3, 8'hAA, acc);
    for (int f = 0; f < 2; f++) begin
      collect_frame(3, 4, 11, bits, uns, bd, gap, fc, rs, rl, to);
      d = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
      e = frame_bits(d, 0, 11);
      n_checks++;
      if (bits !== e || uns !== 0 || to) begin
        n_fail++; $display("FAIL stop2_frame%0d: got %h want %h unstable %0d", f, bits, e, uns);
      end
      if (f == 1) begin
        n_checks++;
        if (gap !== 0 || bd !== 0) begin
          n_fail++; $display("FAIL stop2_gap: idle cycles %0d busy drops %0d want 0/0", gap, bd);
        end
      end
    end
    @(negedge clk);
    n_checks++;
    if (busy_w[3] !== 1'b0) begin n_fail++; $display("FAIL stop2_end_busy: got %b want 0", busy_w[3]); end
  endtask

  task automatic test_reset_mid_frame();
    bit acc; int w; int bad;
    push_byte(0, 8'h3C, acc);
    push_byte(0, 8'hC3, acc);
    push_byte(0, 8'h5A, acc);
    w = 0;
    while (txd_w[0] !== 1'b0 && w < 10) begin @(negedge clk); w++; end
    repeat (1300 * 4 + 650) @(negedge clk);
    n_checks++;
    if (fc_w[0] !== 3'(exp_q.size() - 1)) begin
      n_fail++; $display("FAIL midreset_pre_count: got %0d want %0d", fc_w[0], exp_q.size() - 1);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({txd_w[0], busy_w[0], rdy_w[0], fc_w[0]} !== {1'b1, 1'b0, 1'b1, 3'd0}) begin
      n_fail++; $display("FAIL midreset_async: txd/busy/ready/count got %b/%b/%b/%0d want 1/0/1/0",
                         txd_w[0], busy_w[0], rdy_w[0], fc_w[0]);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (4000) begin
      @(negedge clk);
      if (txd_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || fc_w[0] !== 3'd0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL midreset_quiet: %0d active cycles want 0", bad); end
  endtask

  task automatic test_loopback();
    fork
      begin
        bit acc;
        push_byte(0, 8'h00, acc);
        push_byte(0, 8'hFF, acc);
        push_byte(0, 8'h55, acc);
      end
      begin
        logic [7:0] rx, d; logic start_ok, ferr; int w;
        for (int f = 0; f < 3; f++) begin
          w = 0;
          while (txd_w[0] !== 1'b0 && w < 30000) begin @(negedge clk); w++; end
          if (txd_w[0] !== 1'b0) begin
            n_checks++; n_fail++;
            $display("FAIL loopback_timeout: frame %0d never started", f);
            break;
          end
          repeat (650) @(negedge clk);
          start_ok = (txd_w[0] === 1'b0);
          for (int k = 0; k < 8; k++) begin
            repeat (1300) @(negedge clk);
            rx[k] = txd_w[0];
          end
          repeat (1300) @(negedge clk);
          ferr = (txd_w[0] !== 1'b1) || !start_ok;
          d = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
          n_checks++;
          if (rx !== d) begin n_fail++; $display("FAIL loopback_byte%0d: got %h want %h", f, rx, d); end
          n_checks++;
          if (ferr) begin n_fail++; $display("FAIL loopback_framing%0d: framing error got 1 want 0", f); end
        end
      end
    join
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) dat[i] = 8'h00;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_single_byte();
    test_parity(1, 1, 8'h07, 1'b1);
    test_parity(2, 2, 8'h07, 1'b0);
    test_parity(1, 1, 8'h00, 1'b0);
    test_burst();
    test_two_stop();
    test_reset_mid_frame();
    test_loopback();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
